// File: rtl/pair_pkg.sv
// Shared types and constants for the pair-window counter block.
package pair_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } pair_state_e;

    localparam int PAIR_WIN_LEN_DEFAULT = 16;

    // Width that holds every count 0..win_len inclusive.
    function automatic int pair_cnt_w(input int win_len);
        return $clog2(win_len + 1);
    endfunction

endpackage

// File: rtl/pair_run_tracker.sv
// Longest run of consecutive sampled pair flags within one window.
// peak is combinational so the close-cycle sample is already included.
module pair_run_tracker import pair_pkg::*; #(
    parameter int CNT_W = pair_cnt_w(PAIR_WIN_LEN_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic             pair_in,
    input  logic             win_close,
    output logic [CNT_W-1:0] peak
);

    logic [CNT_W-1:0] run_q;
    logic [CNT_W-1:0] peak_q;
    logic [CNT_W-1:0] run_next;

    always_comb begin
        run_next = '0;
        if (pair_in) begin
            run_next = run_q + CNT_W'(1);
        end
        peak = peak_q;
        if (sample_en && (run_next > peak_q)) begin
            peak = run_next;
        end
    end

    // Unqualified cycles hold both counters, so gaps never break a run.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_q  <= '0;
            peak_q <= '0;
        end else if (win_close) begin
            run_q  <= '0;
            peak_q <= '0;
        end else if (sample_en) begin
            run_q  <= run_next;
            peak_q <= peak;
        end
    end

endmodule

// File: rtl/pair_window_counter.sv
// Counts pair-detect flags over windows of WIN_LEN samples and hands results to a reader.
// Build option PAIR_RUN_EN adds the longest-run tracker; otherwise max_run is tied to 0.
//
//  state | meaning
//  IDLE  | waiting for the first qualified sample after reset
//  COUNT | windows running back-to-back; left only through reset
module pair_window_counter import pair_pkg::*; #(
    parameter  int WIN_LEN = PAIR_WIN_LEN_DEFAULT,
    localparam int CNT_W   = pair_cnt_w(WIN_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pair_in,
    input  logic             sample_en,
    output logic [CNT_W-1:0] cnt_data,
    output logic [CNT_W-1:0] max_run,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic             overrun,
    input  logic             ovr_clr,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_LEFT = CNT_W'(WIN_LEN - 1);

    pair_state_e      state;
    logic [CNT_W-1:0] samples_left;
    logic [CNT_W-1:0] pair_cnt;
    logic [CNT_W-1:0] final_cnt;
    logic             win_close;
    logic             accept;
    logic             load;
    logic             drop;

    assign win_close = sample_en && (samples_left == '0);
    assign final_cnt = pair_cnt + CNT_W'(pair_in);
    assign accept    = cnt_valid && cnt_ready;
    assign load      = win_close && (!cnt_valid || cnt_ready);
    assign drop      = win_close && !load;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sample_en) begin
                        state <= COUNT;
                        busy  <= 1'b1;
                    end
                end
                COUNT: begin
                    state <= COUNT;
                    busy  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Window timer counts down to terminal count 0; samples count in IDLE too.
    always_ff @(posedge clk) begin
        if (reset) begin
            samples_left <= LAST_LEFT;
            pair_cnt     <= '0;
        end else if (win_close) begin
            samples_left <= LAST_LEFT;
            pair_cnt     <= '0;
        end else if (sample_en) begin
            samples_left <= samples_left - CNT_W'(1);
            pair_cnt     <= final_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_data  <= '0;
            cnt_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                cnt_data  <= final_cnt;
                cnt_valid <= 1'b1;
            end else if (accept) begin
                cnt_valid <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef PAIR_RUN_EN
    logic [CNT_W-1:0] run_peak;

    pair_run_tracker #(
        .CNT_W (CNT_W)
    ) u_run_tracker (
        .clk       (clk),
        .reset     (reset),
        .sample_en (sample_en),
        .pair_in   (pair_in),
        .win_close (win_close),
        .peak      (run_peak)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            max_run <= '0;
        end else if (load) begin
            max_run <= run_peak;
        end
    end
`else
    assign max_run = '0;
`endif

endmodule

// File: tb/tb_pair_window_counter.sv
// Directed bench for pair_window_counter with WIN_LEN=4; max_run expectations follow PAIR_RUN_EN.
module tb_pair_window_counter;

    localparam int WIN_LEN = 4;
    localparam int CNT_W   = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             pair_in;
    logic             sample_en;
    logic [CNT_W-1:0] cnt_data;
    logic [CNT_W-1:0] max_run;
    logic             cnt_valid;
    logic             cnt_ready;
    logic             overrun;
    logic             ovr_clr;
    logic             busy;

    int errors = 0;
    int checks = 0;

    pair_window_counter #(.WIN_LEN(WIN_LEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .pair_in   (pair_in),
        .sample_en (sample_en),
        .cnt_data  (cnt_data),
        .max_run   (max_run),
        .cnt_valid (cnt_valid),
        .cnt_ready (cnt_ready),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic int exp_run(input int v);
`ifdef PAIR_RUN_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input logic en, input logic p);
        sample_en = en;
        pair_in   = p;
        tick();
    endtask

    initial begin
        reset = 1'b1; pair_in = 1'b0; sample_en = 1'b0;
        cnt_ready = 1'b0; ovr_clr = 1'b0;

        // 1: reset then window 1,0,1,1
        tick(); tick();
        check("rst_valid", cnt_valid, 0);
        check("rst_data", cnt_data, 0);
        check("rst_max", max_run, 0);
        check("rst_ovr", overrun, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0; cnt_ready = 1'b1;
        sample(1, 1);
        check("s1_busy", busy, 1);
        sample(1, 0);
        sample(1, 1);
        check("s1_valid_early", cnt_valid, 0);
        sample(1, 1);
        check("s1_valid", cnt_valid, 1);
        check("s1_data", cnt_data, 3);
        check("s1_max", max_run, exp_run(2));
        sample(0, 0);
        check("s1_drop_valid", cnt_valid, 0);

        // 2: all-ones then all-zeros back to back
        sample(1, 1); sample(1, 1); sample(1, 1); sample(1, 1);
        check("s2a_valid", cnt_valid, 1);
        check("s2a_data", cnt_data, 4);
        check("s2a_max", max_run, exp_run(4));
        sample(1, 0);
        check("s2_accept", cnt_valid, 0);
        sample(1, 0); sample(1, 0);
        check("s2b_valid_early", cnt_valid, 0);
        sample(1, 0);
        check("s2b_valid", cnt_valid, 1);
        check("s2b_data", cnt_data, 0);
        check("s2b_max", max_run, 0);
        sample(0, 0);
        check("s2b_accept", cnt_valid, 0);

        // 3: reader stalled over two windows
        cnt_ready = 1'b0;
        sample(1, 1); sample(1, 1); sample(1, 0); sample(1, 0);
        check("s3a_valid", cnt_valid, 1);
        check("s3a_data", cnt_data, 2);
        check("s3a_max", max_run, exp_run(2));
        sample(1, 1); sample(1, 1); sample(1, 1);
        check("s3_ovr_early", overrun, 0);
        sample(1, 1);
        check("s3_ovr", overrun, 1);
        check("s3_hold_valid", cnt_valid, 1);
        check("s3_hold_data", cnt_data, 2);
        check("s3_hold_max", max_run, exp_run(2));
        cnt_ready = 1'b1;
        sample(0, 0);
        check("s3_accept", cnt_valid, 0);
        cnt_ready = 1'b0; ovr_clr = 1'b1;
        sample(0, 0);
        check("s3_clr", overrun, 0);
        ovr_clr = 1'b0;

        // 3b: drain and load in the same close cycle
        sample(1, 1); sample(1, 0); sample(1, 0); sample(1, 0);
        check("s3b_data1", cnt_data, 1);
        check("s3b_max1", max_run, exp_run(1));
        sample(1, 0); sample(1, 1); sample(1, 1);
        cnt_ready = 1'b1;
        sample(1, 0);
        cnt_ready = 1'b0;
        check("s3b_valid", cnt_valid, 1);
        check("s3b_data2", cnt_data, 2);
        check("s3b_max2", max_run, exp_run(2));
        check("s3b_ovr", overrun, 0);

        // 3c: drop and clear in the same cycle, set wins
        sample(1, 1); sample(1, 1); sample(1, 1);
        ovr_clr = 1'b1;
        sample(1, 1);
        check("s3c_set_wins", overrun, 1);
        check("s3c_hold_data", cnt_data, 2);
        sample(0, 0);
        check("s3c_clr", overrun, 0);
        ovr_clr = 1'b0; cnt_ready = 1'b1;
        sample(0, 0);
        check("s3c_accept", cnt_valid, 0);

        // 4: sample_en toggling, gaps carry pair_in=0 and must be ignored
        sample(1, 1); sample(0, 0); sample(1, 1); sample(0, 0);
        sample(1, 1); sample(0, 0);
        check("s4_valid_early", cnt_valid, 0);
        sample(1, 1);
        check("s4_valid", cnt_valid, 1);
        check("s4_data", cnt_data, 4);
        check("s4_max", max_run, exp_run(4));
        sample(0, 0);
        check("s4_accept", cnt_valid, 0);

        // 5: reset mid-window with an unread result pending
        cnt_ready = 1'b0;
        sample(1, 1); sample(1, 1); sample(1, 0); sample(1, 1);
        check("s5_pending", cnt_valid, 1);
        check("s5_pending_data", cnt_data, 3);
        check("s5_pending_max", max_run, exp_run(2));
        sample(1, 1); sample(1, 1);
        reset = 1'b1;
        sample(0, 0);
        check("s5_rst_valid", cnt_valid, 0);
        check("s5_rst_busy", busy, 0);
        check("s5_rst_data", cnt_data, 0);
        reset = 1'b0; cnt_ready = 1'b1;
        sample(1, 1);
        check("s5_busy", busy, 1);
        sample(1, 0); sample(1, 0);
        check("s5_valid_early", cnt_valid, 0);
        sample(1, 1);
        check("s5_valid", cnt_valid, 1);
        check("s5_data", cnt_data, 2);
        check("s5_max", max_run, exp_run(1));
        sample(0, 0);
        check("s5_accept", cnt_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
